// File: rtl/sync_lifo_mc_pkg.sv
// Shared types and helpers for the multi-channel LIFO (package sync_lifo_pkg).
// Holds the operation encoding, the modulo pointer helpers and the width helpers.
package sync_lifo_pkg;

  typedef enum logic [1:0] {OP_NONE, OP_PUSH, OP_POP, OP_REPL} lifo_op_e;

  // Channel-select width; a single channel still needs a 1-bit select.
  function automatic int unsigned ch_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Occupancy width: must be able to hold the value DEPTH itself.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // Pointer increment with explicit wrap, so DEPTH need not be a power of 2.
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr >= depth - 1) ? 0 : ptr + 1;
  endfunction

  // Pointer decrement with explicit wrap.
  function automatic int unsigned ptr_dec(input int unsigned ptr, input int unsigned depth);
    return (ptr == 0) ? depth - 1 : ptr - 1;
  endfunction

endpackage

// File: rtl/sync_lifo_mc_if.sv
// Request/response bundle of the multi-channel LIFO.
// master drives operations, slave (the LIFO) returns the state of ch_sel.
interface sync_lifo_mc_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CH     = 2,
  parameter int CH_W       = 1,
  parameter int CNT_W      = 6
);
  logic                  enable;
  logic [CH_W-1:0]       ch_sel;
  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] data_i;
  logic                  err_clr;
  logic [DATA_WIDTH-1:0] data_o;
  logic [CNT_W-1:0]      count_o;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [NUM_CH-1:0]     ovf_err;
  logic [NUM_CH-1:0]     udf_err;

  modport master (
    output enable, ch_sel, push, pop, data_i, err_clr,
    input  data_o, count_o, full, empty, almost_full, almost_empty, ovf_err, udf_err
  );

  modport slave (
    input  enable, ch_sel, push, pop, data_i, err_clr,
    output data_o, count_o, full, empty, almost_full, almost_empty, ovf_err, udf_err
  );
endinterface

// File: rtl/sync_lifo_mc_lifo_ch_ctrl.sv
// Per-channel stack controller: top pointer, occupancy and sticky error flags.
// Decodes the op for its channel and produces the storage write enable/slot.
// Build option SYNC_LIFO_WRAP_EN: push on a full channel overwrites the oldest entry
// instead of being dropped.
module lifo_ch_ctrl
  import sync_lifo_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int PTR_W = $clog2(DEPTH),
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             sel,
  input  logic             push,
  input  logic             pop,
  input  logic             err_clr,
  output logic             wr_en_o,
  output logic [PTR_W-1:0] wr_slot_o,
  output logic [PTR_W-1:0] top_slot_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic             ovf_o,
  output logic             udf_o
);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [PTR_W-1:0] tp_q, tp_d, tp_inc, tp_dec;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d, udf_q, udf_d;
  logic             is_empty, is_full;
  lifo_op_e         op;

  assign tp_inc     = PTR_W'(ptr_inc(32'(tp_q), DEPTH));
  assign tp_dec     = PTR_W'(ptr_dec(32'(tp_q), DEPTH));
  assign is_empty   = (cnt_q == '0);
  assign is_full    = (cnt_q == CNT_FULL);
  assign top_slot_o = tp_dec;
  assign cnt_o      = cnt_q;
  assign ovf_o      = ovf_q;
  assign udf_o      = udf_q;

  // Decode push/pop into one op; push&pop on an empty stack degrades to a push.
  always_comb begin
    op = OP_NONE;
    if (push && pop)  op = is_empty ? OP_PUSH : OP_REPL;
    else if (push)    op = OP_PUSH;
    else if (pop)     op = OP_POP;
  end

  // Next state of pointer, count and error flags; error set beats err_clr.
  always_comb begin
    tp_d      = tp_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    udf_d     = udf_q;
    wr_en_o   = 1'b0;
    wr_slot_o = tp_q;
    if (enable) begin
      if (err_clr) begin
        ovf_d = 1'b0;
        udf_d = 1'b0;
      end
      if (sel) begin
        case (op)
          OP_PUSH: begin
            if (pop) udf_d = 1'b1;
            if (!is_full) begin
              wr_en_o = 1'b1;
              tp_d    = tp_inc;
              cnt_d   = cnt_q + 1'b1;
            end else begin
              ovf_d = 1'b1;
`ifdef SYNC_LIFO_WRAP_EN
              wr_en_o = 1'b1;
              tp_d    = tp_inc;
`endif
            end
          end
          OP_POP: begin
            if (is_empty) begin
              udf_d = 1'b1;
            end else begin
              tp_d  = tp_dec;
              cnt_d = cnt_q - 1'b1;
            end
          end
          OP_REPL: begin
            wr_en_o   = 1'b1;
            wr_slot_o = tp_dec;
          end
          default: ;
        endcase
      end
    end
  end

  // Channel state registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tp_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      tp_q  <= tp_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

endmodule

// File: rtl/sync_lifo_mc.sv
// Multi-channel synchronous LIFO: NUM_CH independent stacks sharing one storage array.
// Per-channel control lives in lifo_ch_ctrl; this level holds storage and ch_sel muxing.
// Build option SYNC_LIFO_WRAP_EN (handled in lifo_ch_ctrl) selects wrap-on-full pushes.
module sync_lifo_mc
  import sync_lifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 32,
  parameter int NUM_CH     = 2,
  parameter int AF_LEVEL   = DEPTH - 1,
  parameter int AE_LEVEL   = 1
) (
  input logic           clk,
  input logic           rst,
  sync_lifo_mc_if.slave bus
);

  localparam int CH_W  = ch_width(NUM_CH);
  localparam int CNT_W = cnt_width(DEPTH);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] CNT_AE   = CNT_W'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem [NUM_CH][DEPTH];
  logic [NUM_CH-1:0]     ch_match;
  logic [NUM_CH-1:0]     wr_en;
  logic [NUM_CH-1:0]     ovf, udf;
  logic [PTR_W-1:0]      wr_slot  [NUM_CH];
  logic [PTR_W-1:0]      top_slot [NUM_CH];
  logic [CNT_W-1:0]      cnt      [NUM_CH];
  logic [CNT_W-1:0]      sel_cnt;
  logic [DATA_WIDTH-1:0] sel_data;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign ch_match[g] = (bus.ch_sel == CH_W'(g));

    lifo_ch_ctrl #(
      .DEPTH (DEPTH),
      .PTR_W (PTR_W),
      .CNT_W (CNT_W)
    ) u_ctrl (
      .clk        (clk),
      .rst        (rst),
      .enable     (bus.enable),
      .sel        (ch_match[g]),
      .push       (bus.push),
      .pop        (bus.pop),
      .err_clr    (bus.err_clr),
      .wr_en_o    (wr_en[g]),
      .wr_slot_o  (wr_slot[g]),
      .top_slot_o (top_slot[g]),
      .cnt_o      (cnt[g]),
      .ovf_o      (ovf[g]),
      .udf_o      (udf[g])
    );
  end

  // Shared storage, not reset; only the addressed channel ever raises its write enable.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (wr_en[c]) mem[c][wr_slot[c]] <= bus.data_i;
    end
  end

  // Select count and top entry of ch_sel; an out-of-range select reads as empty.
  always_comb begin
    sel_cnt  = '0;
    sel_data = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_match[c]) begin
        sel_cnt  = cnt[c];
        sel_data = mem[c][top_slot[c]];
      end
    end
  end

  // Status outputs derive only from registered counts, never from push/pop.
  always_comb begin
    bus.data_o       = (sel_cnt == '0) ? '0 : sel_data;
    bus.count_o      = sel_cnt;
    bus.full         = (sel_cnt == CNT_FULL);
    bus.empty        = (sel_cnt == '0);
    bus.almost_full  = (sel_cnt >= CNT_AF);
    bus.almost_empty = (sel_cnt <= CNT_AE);
    bus.ovf_err      = ovf;
    bus.udf_err      = udf;
  end

endmodule

// File: tb/tb_sync_lifo_mc.sv
// Directed self-checking bench for sync_lifo_mc (DEPTH=5, NUM_CH=2, AF_LEVEL=4).
// Honours SYNC_LIFO_WRAP_EN to pick the full-push expectations.
module tb_sync_lifo_mc;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  sync_lifo_mc_if #(.DATA_WIDTH(8), .NUM_CH(2), .CH_W(1), .CNT_W(3)) bus ();

  sync_lifo_mc #(
    .DATA_WIDTH (8),
    .DEPTH      (5),
    .NUM_CH     (2),
    .AF_LEVEL   (4),
    .AE_LEVEL   (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] model0 [$];
  logic [7:0] model1 [$];
  logic [7:0] exp_q  [$];
  int n_cmp  = 0;
  int n_fail = 0;

  // One comparison: counted, and reported on mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, clock it, then return to idle 1ns after the edge.
  task automatic applyStimulus(input logic en, input logic ch, input logic ps, input logic pp,
                               input logic [7:0] d, input logic clr);
    bus.enable  = en;
    bus.ch_sel  = ch;
    bus.push    = ps;
    bus.pop     = pp;
    bus.data_i  = d;
    bus.err_clr = clr;
    @(posedge clk);
    #1;
    bus.enable  = 1'b1;
    bus.push    = 1'b0;
    bus.pop     = 1'b0;
    bus.err_clr = 1'b0;
  endtask

  // Push to a non-full channel and record it in the model.
  task automatic doPush(input logic ch, input logic [7:0] d);
    applyStimulus(1'b1, ch, 1'b1, 1'b0, d, 1'b0);
    if (ch) model1.push_back(d);
    else    model0.push_back(d);
  endtask

  // Pop: the expected top goes to the scoreboard, then is checked against data_o.
  task automatic doPop(input logic ch);
    bus.ch_sel = ch;
    #1;
    if (ch) exp_q.push_back(model1.pop_back());
    else    exp_q.push_back(model0.pop_back());
    checkOutput("pop_top", 32'(bus.data_o), 32'(exp_q.pop_front()));
    applyStimulus(1'b1, ch, 1'b0, 1'b1, 8'h00, 1'b0);
  endtask

  initial begin
    rst         = 1'b1;
    bus.enable  = 1'b0;
    bus.ch_sel  = 1'b0;
    bus.push    = 1'b0;
    bus.pop     = 1'b0;
    bus.data_i  = 8'h00;
    bus.err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_count", 32'(bus.count_o), 32'd0);
    checkOutput("rst_empty", 32'(bus.empty), 32'd1);
    checkOutput("rst_full", 32'(bus.full), 32'd0);
    checkOutput("rst_data", 32'(bus.data_o), 32'd0);
    rst = 1'b0;

    // Error and traffic before a mid-run reset
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
    checkOutput("udf_pre_rst", 32'(bus.udf_err), 32'h2);
    for (int i = 1; i <= 5; i++) doPush(1'b0, 8'(i));
    checkOutput("ch0_count5", 32'(bus.count_o), 32'd5);
    rst = 1'b1;
    #1;
    checkOutput("midrst_count", 32'(bus.count_o), 32'd0);
    checkOutput("midrst_empty", 32'(bus.empty), 32'd1);
    checkOutput("midrst_data", 32'(bus.data_o), 32'd0);
    checkOutput("midrst_udf", 32'(bus.udf_err), 32'd0);
    checkOutput("midrst_ovf", 32'(bus.ovf_err), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model0.delete();

    // Fill and drain channel 1
    for (int i = 0; i < 5; i++) doPush(1'b1, 8'h11 + 8'(i));
    checkOutput("ch1_full", 32'(bus.full), 32'd1);
    checkOutput("ch1_count", 32'(bus.count_o), 32'd5);
    checkOutput("ch1_top", 32'(bus.data_o), 32'h15);
    checkOutput("ch1_af", 32'(bus.almost_full), 32'd1);
    bus.ch_sel = 1'b0;
    #1;
    checkOutput("ch0_untouched", 32'(bus.count_o), 32'd0);
    for (int i = 0; i < 5; i++) doPop(1'b1);
    checkOutput("ch1_drained", 32'(bus.empty), 32'd1);
    checkOutput("ch1_drained_data", 32'(bus.data_o), 32'd0);

    // Push onto a full channel 0
    for (int i = 0; i < 5; i++) doPush(1'b0, 8'h11 + 8'(i));
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'hAA, 1'b0);
`ifdef SYNC_LIFO_WRAP_EN
    void'(model0.pop_front());
    model0.push_back(8'hAA);
    checkOutput("fullpush_data", 32'(bus.data_o), 32'hAA);
`else
    checkOutput("fullpush_data", 32'(bus.data_o), 32'h15);
`endif
    checkOutput("fullpush_count", 32'(bus.count_o), 32'd5);
    checkOutput("fullpush_ovf", 32'(bus.ovf_err), 32'h1);
    checkOutput("fullpush_udf", 32'(bus.udf_err), 32'h0);
    for (int i = 0; i < 5; i++) doPop(1'b0);
    checkOutput("ch0_drained", 32'(bus.empty), 32'd1);

    // Replace on a non-empty stack, then push&pop on an empty stack
    doPush(1'b0, 8'h31);
    doPush(1'b0, 8'h32);
    doPush(1'b0, 8'h33);
    checkOutput("pre_repl_top", 32'(bus.data_o), 32'h33);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 8'h77, 1'b0);
    model0[model0.size() - 1] = 8'h77;
    checkOutput("repl_data", 32'(bus.data_o), 32'h77);
    checkOutput("repl_count", 32'(bus.count_o), 32'd3);
    checkOutput("repl_udf", 32'(bus.udf_err), 32'h0);
    for (int i = 0; i < 3; i++) doPop(1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 8'h44, 1'b0);
    model0.push_back(8'h44);
    checkOutput("pp_empty_count", 32'(bus.count_o), 32'd1);
    checkOutput("pp_empty_data", 32'(bus.data_o), 32'h44);
    checkOutput("pp_empty_udf", 32'(bus.udf_err), 32'h1);
    checkOutput("pp_empty_ae", 32'(bus.almost_empty), 32'd1);

    // Error set beats err_clr for the affected channel only
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1);
    checkOutput("clr_udf_keep", 32'(bus.udf_err), 32'h2);
    checkOutput("clr_ovf", 32'(bus.ovf_err), 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    checkOutput("clr_udf_all", 32'(bus.udf_err), 32'h0);
    checkOutput("clr_ovf_all", 32'(bus.ovf_err), 32'h0);

    // enable=0 holds everything, including err_clr; almost_full threshold
    doPop(1'b0);
    doPush(1'b0, 8'h01);
    doPush(1'b0, 8'h02);
    doPush(1'b0, 8'h03);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h99, 1'b1);
      checkOutput("hold_count", 32'(bus.count_o), 32'd3);
      checkOutput("hold_data", 32'(bus.data_o), 32'h03);
      checkOutput("hold_af", 32'(bus.almost_full), 32'd0);
      checkOutput("hold_udf", 32'(bus.udf_err), 32'h2);
    end
    checkOutput("ae_at3", 32'(bus.almost_empty), 32'd0);
    doPush(1'b0, 8'h04);
    checkOutput("af_at4", 32'(bus.almost_full), 32'd1);
    checkOutput("full_at4", 32'(bus.full), 32'd0);
    doPush(1'b0, 8'h05);
    checkOutput("full_at5", 32'(bus.full), 32'd1);
    checkOutput("top_at5", 32'(bus.data_o), 32'h05);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
